// File: rtl/mem_block_copier.sv
// mem_block_copier: word-block copy engine driving the data-memory port.
// Optional checksum output enabled by defining MCOPY_CHECKSUM_EN.
module mem_block_copier #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] ReadData,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              busy,
`ifdef MCOPY_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              done
);

  localparam int PTR_W = ADDR_W - 2;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << PTR_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [PTR_W-1:0]  src_ptr_q;
  logic [PTR_W-1:0]  dst_ptr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic              busy_q;
  logic              done_q;

  logic [LEN_W-1:0]  len_d;
  logic [PTR_W-1:0]  src_inc_d;
  logic              unused_lsbs;

  // Clamp requested length to the memory size; next source word pointer.
  always_comb begin
    len_d     = (length > MAX_LEN) ? MAX_LEN : length;
    src_inc_d = src_ptr_q + PTR_W'(1);
  end

  assign unused_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

`ifdef MCOPY_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  // Running sum of every word written; cleared on reset and accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      csum_q <= '0;
    end else if (state_q == S_WR) begin
      csum_q <= csum_q + wdata_q;
    end
  end

  assign checksum = csum_q;
`endif

  // Copy FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      rem_q     <= '0;
      address_q <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            src_ptr_q <= src_addr[ADDR_W-1:2];
            dst_ptr_q <= dst_addr[ADDR_W-1:2];
            rem_q     <= len_d;
            if (len_d == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RD;
              address_q <= {src_addr[ADDR_W-1:2], 2'b00};
              rd_q      <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        S_RD: begin
          // The write-data register doubles as the word buffer.
          wdata_q   <= ReadData;
          state_q   <= S_WR;
          address_q <= {dst_ptr_q, 2'b00};
          rd_q      <= 1'b0;
          wr_q      <= 1'b1;
        end
        S_WR: begin
          src_ptr_q <= src_inc_d;
          dst_ptr_q <= dst_ptr_q + PTR_W'(1);
          rem_q     <= rem_q - LEN_W'(1);
          wr_q      <= 1'b0;
          if (rem_q == LEN_W'(1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_RD;
            address_q <= {src_inc_d, 2'b00};
            rd_q      <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign address   = address_q;
  assign writeData = wdata_q;
  assign MemRead   = rd_q;
  assign MemWrite  = wr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_block_copier.sv
// tb_mem_block_copier: directed checks of the block copier against a
// 32-word behavioural memory.
module tb_mem_block_copier;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  src_addr;
  logic [6:0]  dst_addr;
  logic [5:0]  length;
  logic [31:0] ReadData;
  logic [6:0]  address;
  logic [31:0] writeData;
  logic        MemRead;
  logic        MemWrite;
  logic        busy;
  logic        done;
`ifdef MCOPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] mem [32];
  logic        pre_we;
  logic [4:0]  pre_idx;
  logic [31:0] pre_dat;

  int n_cmp;
  int n_bad;

  mem_block_copier dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .length(length),
    .ReadData(ReadData),
    .address(address),
    .writeData(writeData),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .busy(busy),
`ifdef MCOPY_CHECKSUM_EN
    .checksum(checksum),
`endif
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ReadData = mem[address[6:2]];

  always @(posedge clk) begin
    if (MemWrite)
      mem[address[6:2]] <= writeData;
    else if (pre_we)
      mem[pre_idx] <= pre_dat;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    pre_we  = 1'b1;
    pre_idx = 5'(idx);
    pre_dat = val;
    tick();
    pre_we  = 1'b0;
  endtask

  task automatic go(input logic [6:0] s, input logic [6:0] d,
                    input logic [5:0] n);
    src_addr = s;
    dst_addr = d;
    length   = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  logic [6:0] exp_a3 [4];
  logic [6:0] exp_a5 [6];
  int         cyc;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    pre_we = 1'b0;
    pre_idx = '0;
    pre_dat = '0;
    tick();
    tick();
    chk("rst_addr", 32'(address), 32'h0);
    chk("rst_wdata", writeData, 32'h0);
    chk("rst_ctl", {28'h0, MemRead, MemWrite, busy, done}, 32'h0);
`ifdef MCOPY_CHECKSUM_EN
    chk("rst_csum", checksum, 32'h0);
`endif
    reset = 1'b0;
    for (int i = 0; i < 32; i++) poke(i, 32'h0);

    // Test 1: basic three-word copy
    poke(0, 32'd5);
    poke(1, 32'd6);
    poke(2, 32'd7);
    go(7'h00, 7'h40, 6'd3);
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("t1_busy_c%0d", c), 32'(busy), 32'h1);
      chk($sformatf("t1_done_c%0d", c), 32'(done), 32'h0);
      tick();
    end
    chk("t1_done_c7", 32'(done), 32'h1);
    chk("t1_busy_c7", 32'(busy), 32'h0);
    tick();
    chk("t1_done_c8", 32'(done), 32'h0);
    chk("t1_m16", mem[16], 32'd5);
    chk("t1_m17", mem[17], 32'd6);
    chk("t1_m18", mem[18], 32'd7);

    // Test 2: zero-length copy
    go(7'h00, 7'h40, 6'd0);
    chk("t2_done_c1", 32'(done), 32'h1);
    chk("t2_rw_c1", {30'h0, MemRead, MemWrite}, 32'h0);
    chk("t2_busy_c1", 32'(busy), 32'h0);
    tick();
    chk("t2_done_c2", 32'(done), 32'h0);
    chk("t2_rw_c2", {30'h0, MemRead, MemWrite}, 32'h0);
    tick();
    chk("t2_m16", mem[16], 32'd5);

    // Test 3: pointer wrap
    poke(31, 32'hA);
    poke(0, 32'hB);
    exp_a3[0] = 7'h7C;
    exp_a3[1] = 7'h3C;
    exp_a3[2] = 7'h00;
    exp_a3[3] = 7'h40;
    go(7'h7C, 7'h3C, 6'd2);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t3_addr_c%0d", c + 1), 32'(address), 32'(exp_a3[c]));
      tick();
    end
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_m15", mem[15], 32'hA);
    chk("t3_m16", mem[16], 32'hB);

    // Test 4: reset during the write of word 2
    poke(8, 32'h11);
    poke(9, 32'h22);
    poke(10, 32'h33);
    poke(11, 32'h44);
    go(7'h20, 7'h60, 6'd4);
    tick();
    tick();
    tick();
    chk("t4_wr_c4", 32'(MemWrite), 32'h1);
    chk("t4_addr_c4", 32'(address), 32'h64);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_addr0", 32'(address), 32'h0);
    chk("t4_wdata0", writeData, 32'h0);
    chk("t4_ctl0", {28'h0, MemRead, MemWrite, busy, done}, 32'h0);
    tick();
    tick();
    tick();
    chk("t4_idle", {28'h0, MemRead, MemWrite, busy, done}, 32'h0);
    chk("t4_m24", mem[24], 32'h11);
    chk("t4_m25", mem[25], 32'h22);
    chk("t4_m26", mem[26], 32'h0);
    chk("t4_m27", mem[27], 32'h0);

    // Test 5: start while busy is ignored
    poke(0, 32'h100);
    poke(1, 32'h200);
    poke(2, 32'h300);
    exp_a5[0] = 7'h00;
    exp_a5[1] = 7'h50;
    exp_a5[2] = 7'h04;
    exp_a5[3] = 7'h54;
    exp_a5[4] = 7'h08;
    exp_a5[5] = 7'h58;
    go(7'h00, 7'h50, 6'd3);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("t5_addr_c%0d", c + 1), 32'(address), 32'(exp_a5[c]));
      if (c == 1) begin
        src_addr = 7'h40;
        dst_addr = 7'h10;
        length   = 6'd1;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("t5_done_c7", 32'(done), 32'h1);
    chk("t5_m20", mem[20], 32'h100);
    chk("t5_m21", mem[21], 32'h200);
    chk("t5_m22", mem[22], 32'h300);
    chk("t5_m4", mem[4], 32'h0);
    tick();

    // Length clamp: 63 behaves as 32 words
    go(7'h00, 7'h00, 6'd63);
    cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        cyc = c;
        break;
      end
      tick();
    end
    chk("clamp_cycle", 32'(cyc), 32'd65);
    tick();

`ifdef MCOPY_CHECKSUM_EN
    // Test 6: checksum wraps modulo 2^32, clears on new start
    poke(4, 32'hFFFF_FFFF);
    poke(5, 32'h2);
    go(7'h10, 7'h70, 6'd2);
    tick();
    tick();
    tick();
    tick();
    chk("t6_done", 32'(done), 32'h1);
    chk("t6_csum", checksum, 32'h1);
    tick();
    chk("t6_hold", checksum, 32'h1);
    go(7'h00, 7'h00, 6'd0);
    chk("t6_clear", checksum, 32'h0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
